// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: MEM/WB bundle field layout plus the skid-stage
// state and data-select encodings.
package pipe_pkg;

  // MEM/WB bundle fields, packed LSB first in the order listed.
  localparam int MEMTOREG_W      = 3;
  localparam int REGWRITE_W      = 1;
  localparam int DMOUT_W         = 32;
  localparam int ALUS_W          = 32;
  localparam int WREG_W          = 5;
  localparam int PC8_W           = 32;
  localparam int LOAD_EXT_OP_W   = 3;
  localparam int HILO_W          = 32;
  localparam int CP0OUT_W        = 32;
  localparam int J_BRANCH_TYPE_W = 1;
  localparam int ERET_W          = 1;
  localparam int MFC0_W          = 1;

  localparam int MEMTOREG_OFF      = 0;
  localparam int REGWRITE_OFF      = MEMTOREG_OFF + MEMTOREG_W;
  localparam int DMOUT_OFF         = REGWRITE_OFF + REGWRITE_W;
  localparam int ALUS_OFF          = DMOUT_OFF + DMOUT_W;
  localparam int WREG_OFF          = ALUS_OFF + ALUS_W;
  localparam int PC8_OFF           = WREG_OFF + WREG_W;
  localparam int LOAD_EXT_OP_OFF   = PC8_OFF + PC8_W;
  localparam int HILO_OFF          = LOAD_EXT_OP_OFF + LOAD_EXT_OP_W;
  localparam int CP0OUT_OFF        = HILO_OFF + HILO_W;
  localparam int J_BRANCH_TYPE_OFF = CP0OUT_OFF + CP0OUT_W;
  localparam int ERET_OFF          = J_BRANCH_TYPE_OFF + J_BRANCH_TYPE_W;
  localparam int MFC0_OFF          = ERET_OFF + ERET_W;

  localparam int MEMWB_W = MFC0_OFF + MFC0_W;

  // pc8 survives a flush so the EPC can still be recovered from the bubble.
  localparam logic [MEMWB_W-1:0] MEMWB_KEEP =
    {{(MEMWB_W - PC8_W){1'b0}}, {PC8_W{1'b1}}} << PC8_OFF;

  // Encoded as {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } skid_state_e;

  typedef enum logic [1:0] {
    MAIN_HOLD,
    MAIN_IN,
    MAIN_SKID,
    MAIN_FLUSH
  } main_sel_e;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready bundle channel through a pipeline stage: upstream side (in_*)
// and downstream side (out_*).
interface pipe_stage_skid_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  // slave: the stage itself; master: the producer/consumer surrounding it.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: increments on i_inc, sticks at all-ones.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer (registered in_ready),
// flush with KEEP_MASK-preserved bits, and a saturating flush event counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int           W         = 32,
  parameter logic [W-1:0] KEEP_MASK = {W{1'b0}},
  parameter logic [W-1:0] RESET_VAL = {W{1'b0}},
  parameter int           CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  pipe_stage_skid_if.slave  bus,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);

  skid_state_e  r_state;
  skid_state_e  w_next_state;
  main_sel_e    w_main_sel;
  logic         w_skid_load;
  logic [W-1:0] r_main_data;
  logic [W-1:0] r_skid_data;
  logic         w_main_valid;
  logic         w_skid_valid;
  logic         w_acc;
  logic         w_pop;

  assign w_main_valid = r_state[1];
  assign w_skid_valid = r_state[0];
  assign w_acc        = bus.in_valid & bus.in_ready;
  assign w_pop        = w_main_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_main_sel   = MAIN_HOLD;
    w_skid_load  = 1'b0;
    if (flush) begin
      w_next_state = ST_EMPTY;
      w_main_sel   = MAIN_FLUSH;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_next_state = ST_ONE;
            w_main_sel   = MAIN_IN;
          end
        end
        ST_ONE: begin
          if (w_acc && w_pop) begin
            w_main_sel = MAIN_IN;
          end else if (w_acc) begin
            w_next_state = ST_FULL;
            w_skid_load  = 1'b1;
          end else if (w_pop) begin
            w_next_state = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_next_state = ST_ONE;
            w_main_sel   = MAIN_SKID;
          end
        end
        default: w_next_state = ST_EMPTY;
      endcase
    end
  end

  // NOTE: the data registers are reset too, because out_data is visible
  // (as RESET_VAL) while out_valid is low straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_data <= RESET_VAL;
      r_skid_data <= RESET_VAL;
    end else begin
      case (w_main_sel)
        MAIN_IN:    r_main_data <= bus.in_data;
        MAIN_SKID:  r_main_data <= r_skid_data;
        MAIN_FLUSH: r_main_data <= (bus.in_data & KEEP_MASK) | (RESET_VAL & ~KEEP_MASK);
        default:    r_main_data <= r_main_data;
      endcase
      if (w_skid_load) begin
        r_skid_data <= bus.in_data;
      end
    end
  end

  assign bus.out_valid = w_main_valid;
  assign bus.out_data  = r_main_data;
  assign bus.in_ready  = ~w_skid_valid;
  assign occupancy     = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (flush),
    .o_count (flush_cnt)
  );

  a_no_skid_without_main : assert property (
    @(posedge clk) disable iff (rst) r_state != 2'b01
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: the stage is modelled as an ordered
// queue of at most two bundles; a negedge monitor checks every delivered bundle.
module tb_pipe_stage_skid;

  localparam int         W       = 8;
  localparam logic [7:0] KEEP    = 8'hF0;
  localparam logic [7:0] RV      = 8'hA5;
  localparam int         CNT_W   = 2;
  localparam int         CNT_MAX = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] flush_cnt;

  pipe_stage_skid_if #(.W(W)) bus ();

  pipe_stage_skid #(
    .W         (W),
    .KEEP_MASK (KEEP),
    .RESET_VAL (RV),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] sb_q[$];
  int         model_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: a transfer happens at the next edge whenever out_valid & out_ready.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL pop_unexpected: got %0h expected no transfer at %0t", bus.out_data, $time);
      end else begin
        check("out_data", {24'b0, bus.out_data}, {24'b0, sb_q.pop_front()});
      end
    end
  end

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic f);
    logic exp_acc;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    flush         = f;
    exp_acc = v && (sb_q.size() < 2);
    @(posedge clk);
    #1;
    if (f) begin
      sb_q.delete();
      if (model_cnt < CNT_MAX) model_cnt++;
      check("flush_keep", {24'b0, bus.out_data}, {24'b0, (d & KEEP) | (RV & ~KEEP)});
    end else if (exp_acc) begin
      sb_q.push_back(d);
    end
    check("occupancy", {30'b0, occupancy}, 32'(sb_q.size()));
    check("in_ready",  {31'b0, bus.in_ready},  {31'b0, sb_q.size() < 2});
    check("out_valid", {31'b0, bus.out_valid}, {31'b0, sb_q.size() != 0});
    check("flush_cnt", {30'b0, flush_cnt}, 32'(model_cnt));
  endtask

  int sat_exp[6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    #12 rst = 1'b0;
    @(posedge clk);
    #1;

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Back-pressure fills the skid; an offer while full is not accepted.
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush from FULL keeps the masked in_data bits.
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(1'b1, 8'hBB, 1'b0, 1'b0);
    cycle(1'b0, 8'h7C, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush coinciding with a pop and an accepted input.
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b1, 8'hC3, 1'b1, 1'b1);
    repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle while holding an entry.
    cycle(1'b1, 8'h66, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    sb_q.delete();
    model_cnt = 0;
    #1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    check("rst_occupancy", {30'b0, occupancy},     32'd0);
    check("rst_out_data",  {24'b0, bus.out_data},  {24'b0, RV});
    check("rst_flush_cnt", {30'b0, flush_cnt},     32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Flush counter saturation.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      check("sat_cnt", {30'b0, flush_cnt}, 32'(sat_exp[i]));
    end

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0);
    end
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
